// File: rtl/core_dout_deserializer_if.sv
// Bundle of the deserializer's core-side and consumer-side signals.
//   master : environment view (drives requests, nibbles, rd_en, core mask)
//   slave  : deserializer view (drives grants, record, core_num, empty, idle)
// Signals:
//   DUMMY_CORES     [NUM_CORES]      1 = core absent, never granted
//   core_dout_req   [NUM_CORES]      core i holds a record to send
//   core_dout_in    [4*NUM_CORES]    nibble stream, core i on bits [4i+3:4i]
//   core_dout_ready [NUM_CORES]      one-hot, one-cycle grant pulse
//   dout            [4*NIBBLES]      assembled record, nibble 0 in bits [3:0]
//   core_num        [CORE_NUM_MSB+1] core that produced dout
//   empty                            output register holds no record
//   rd_en                            consume the held record
//   idle                             nothing in flight, nothing pending
interface core_dout_deserializer_if #(
  parameter int unsigned NUM_CORES    = 16,
  parameter int unsigned NIBBLES      = 16,
  parameter int unsigned CORE_NUM_MSB = 3
);
  logic [NUM_CORES-1:0]   DUMMY_CORES;
  logic [NUM_CORES-1:0]   core_dout_req;
  logic [4*NUM_CORES-1:0] core_dout_in;
  logic [NUM_CORES-1:0]   core_dout_ready;
  logic [4*NIBBLES-1:0]   dout;
  logic [CORE_NUM_MSB:0]  core_num;
  logic                   empty;
  logic                   rd_en;
  logic                   idle;

  modport master (
    output DUMMY_CORES, core_dout_req, core_dout_in, rd_en,
    input  core_dout_ready, dout, core_num, empty, idle
  );

  modport slave (
    input  DUMMY_CORES, core_dout_req, core_dout_in, rd_en,
    output core_dout_ready, dout, core_num, empty, idle
  );
endinterface

// File: rtl/core_dout_deserializer.sv
// Round-robin collector of 4-bit serialized result streams from NUM_CORES cores.
// A granted core streams NIBBLES nibbles starting two cycles after its grant pulse;
// the rebuilt record is handed out through a one-entry FWFT register tagged with
// the core index.
// Ports:
//   CLK    clock
//   rst_n  asynchronous active-low reset
//   bus    core_dout_deserializer_if.slave (requests/nibbles in, grant and record out)
module core_dout_deserializer #(
  parameter int unsigned NUM_CORES    = 16,
  parameter int unsigned NIBBLES      = 16,
  parameter int unsigned CORE_NUM_MSB = 3
) (
  input logic                      CLK,
  input logic                      rst_n,
  core_dout_deserializer_if.slave  bus
);

  localparam int unsigned DoutW = 4 * NIBBLES;
  localparam int unsigned IdxW  = CORE_NUM_MSB + 1;
  localparam int unsigned CntW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGrant   = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StRecv    = 3'd3;
  localparam logic [2:0] StWaitOut = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IdxW-1:0]  g_q, g_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DoutW-1:0] shift_q, shift_d;
  logic [DoutW-1:0] dout_q, dout_d;
  logic [IdxW-1:0]  core_num_q, core_num_d;
  logic             empty_q, empty_d;

  logic [NUM_CORES-1:0] eligible;
  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [3:0]           lane;

  assign eligible = bus.core_dout_req & ~bus.DUMMY_CORES;
  assign lane     = 4'(bus.core_dout_in >> {g_q, 2'b00});

  // Round-robin scan starting just after the last winner, wrapping modulo NUM_CORES.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 1; off <= NUM_CORES; off++) begin
      idx = (32'(last_q) + off) % NUM_CORES;
      if (!win_found && |(eligible & (NUM_CORES'(1) << idx))) begin
        win_found = 1'b1;
        win_idx   = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    core_num_d = core_num_q;
    empty_d    = empty_q;

    // A consume frees the register; a load in WAIT_OUT below overrides this.
    if (bus.rd_en && !empty_q) empty_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          g_d     = win_idx;
          last_d  = win_idx;
          state_d = StGrant;
        end
      end
      StGrant: state_d = StWait;
      // Slot for the core's registered output path.
      StWait: begin
        cnt_d   = '0;
        state_d = StRecv;
      end
      StRecv: begin
        shift_d = (shift_q & ~(DoutW'(4'hF) << {cnt_q, 2'b00}))
                | (DoutW'(lane) << {cnt_q, 2'b00});
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NIBBLES - 1)) state_d = StWaitOut;
      end
      StWaitOut: begin
        if (empty_q || bus.rd_en) begin
          dout_d     = shift_q;
          core_num_d = g_q;
          empty_d    = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      g_q        <= '0;
      last_q     <= IdxW'(NUM_CORES - 1);
      cnt_q      <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      core_num_q <= '0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      core_num_q <= core_num_d;
      empty_q    <= empty_d;
    end
  end

  assign bus.core_dout_ready = (state_q == StGrant) ? (NUM_CORES'(1) << g_q) : '0;
  assign bus.dout            = dout_q;
  assign bus.core_num        = core_num_q;
  assign bus.empty           = empty_q;
  assign bus.idle            = (state_q == StIdle) && empty_q && !(|eligible);

endmodule

// File: tb/tb_core_dout_deserializer.sv
// Scoreboard bench: a core model answers each grant with its stream and pushes the
// expected record; a monitor pops and compares whenever a record is consumed.
module tb_core_dout_deserializer;
  localparam int NC   = 16;
  localparam int NIB  = 16;
  localparam int CMSB = 3;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  core_dout_deserializer_if #(.NUM_CORES(NC), .NIBBLES(NIB), .CORE_NUM_MSB(CMSB)) bus();

  core_dout_deserializer #(.NUM_CORES(NC), .NIBBLES(NIB), .CORE_NUM_MSB(CMSB)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0, n_fail = 0, n_ready = 0, n_pop = 0;
  logic [63:0] core_data [NC];
  logic [67:0] sb_q [$];
  int grant_log [$];
  int grant_cyc [$];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Core array model: answers a grant seen in cycle G with nibble k during G+2+k.
  task automatic core_model();
    int g;
    bit aborted;
    forever begin
      @(negedge CLK);
      if (rst_n && bus.core_dout_ready != '0) begin
        g = 0;
        for (int i = 0; i < NC; i++) if (bus.core_dout_ready[i]) g = i;
        bus.core_dout_req[g] = 1'b0;
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
        aborted = 1'b0;
        @(posedge CLK);
        for (int k = 0; k < NIB; k++) begin
          @(posedge CLK);
          #1;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          bus.core_dout_in[4*g +: 4] = core_data[g][4*k +: 4];
        end
        if (!aborted) sb_q.push_back({4'(g), core_data[g]});
      end
    end
  endtask

  task automatic monitor();
    logic [67:0] e;
    forever begin
      @(negedge CLK);
      if (rst_n) begin
        if (bus.core_dout_ready != '0) begin
          n_ready++;
          check("ready_onehot", 68'($countones(bus.core_dout_ready)), 68'd1);
        end
        if (!bus.empty && bus.rd_en) begin
          n_pop++;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_record: got core %0d data 0x%h, expected none",
                     bus.core_num, bus.dout);
          end else begin
            e = sb_q.pop_front();
            check("record_core", 68'(bus.core_num), 68'(e[67:64]));
            check("record_data", 68'(bus.dout), 68'(e[63:0]));
          end
        end
      end
    end
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int t = 0;
    while (grant_log.size() < n && t < budget) begin
      @(posedge CLK);
      #2;
      t++;
    end
    if (grant_log.size() < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d grants, expected %0d", name, grant_log.size(), n);
    end
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int t = 0;
    while (n_pop < n && t < budget) begin
      @(posedge CLK);
      #2;
      t++;
    end
    if (n_pop < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d records, expected %0d", name, n_pop, n);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  initial begin
    int t, base_pop, base_ready;
    int exp_g2 [4];
    exp_g2 = '{0, 5, 15, 0};
    rst_n = 1'b0;
    bus.DUMMY_CORES   = '0;
    bus.core_dout_req = '0;
    bus.rd_en         = 1'b0;
    bus.core_dout_in  = {$urandom, $urandom};
    for (int i = 0; i < NC; i++) core_data[i] = {$urandom, $urandom};

    fork
      core_model();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    step(2);
    @(negedge CLK);
    check("rst_ready", 68'(bus.core_dout_ready), 68'd0);
    check("rst_empty", 68'(bus.empty), 68'd1);
    check("rst_dout", 68'(bus.dout), 68'd0);
    check("rst_core_num", 68'(bus.core_num), 68'd0);
    check("rst_idle", 68'(bus.idle), 68'd1);
    step(1);
    rst_n = 1'b1;

    // 1: single record from core 3, latency and content
    core_data[3] = 64'hFEDC_BA98_7654_3210;
    step(1);
    bus.core_dout_req[3] = 1'b1;
    wait_grants(1, 10, "t1_grant");
    check("t1_grant_core", 68'(grant_log[0]), 68'd3);
    t = 0;
    while (bus.empty && t < 40) begin
      @(negedge CLK);
      t++;
    end
    check("t1_visible", 68'(bus.empty), 68'd0);
    // Last nibble lands at the end of G+17, WAIT_OUT loads at the end of G+18.
    check("t1_latency", 68'(cyc - grant_cyc[0]), 68'd19);
    check("t1_dout", 68'(bus.dout), 68'hFEDC_BA98_7654_3210);
    check("t1_core_num", 68'(bus.core_num), 68'd3);
    check("t1_one_pulse", 68'(n_ready), 68'd1);
    step(1);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    @(negedge CLK);
    check("t1_drained", 68'(bus.empty), 68'd1);
    check("t1_dout_hold", 68'(bus.dout), 68'hFEDC_BA98_7654_3210);
    check("t1_popped", 68'(n_pop), 68'd1);

    // 6: rd_en while empty
    step(1);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    @(negedge CLK);
    check("t6_empty", 68'(bus.empty), 68'd1);
    check("t6_dout", 68'(bus.dout), 68'hFEDC_BA98_7654_3210);
    check("t6_no_pop", 68'(n_pop), 68'd1);
    check("t6_idle", 68'(bus.idle), 68'd1);

    // 2: cores 0,5,15 together with a draining consumer, then core 0 again
    do_reset();
    clear_logs();
    base_pop = n_pop;
    core_data[0]  = 64'h0123_4567_89AB_CDEF;
    core_data[5]  = 64'h5555_AAAA_0F0F_F0F0;
    core_data[15] = 64'hDEAD_BEEF_CAFE_F00D;
    bus.rd_en = 1'b1;
    bus.core_dout_req = 16'h8021;
    wait_grants(1, 10, "t2_first");
    step(1);
    bus.core_dout_req[0] = 1'b1;
    wait_pops(base_pop + 4, 200, "t2_records");
    check("t2_n_grants", 68'(grant_log.size()), 68'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), 68'(grant_log[i]), 68'(exp_g2[i]));
    for (int i = 1; i < 4 && i < grant_cyc.size(); i++)
      check($sformatf("t2_period%0d", i), 68'(grant_cyc[i] - grant_cyc[i-1]), 68'd20);

    // 3: held record stalls the FSM in WAIT_OUT; read replaces in the same edge
    bus.rd_en = 1'b0;
    step(2);
    clear_logs();
    base_pop   = n_pop;
    core_data[7]  = 64'h7777_0000_1234_ABCD;
    core_data[9]  = 64'h9999_FFFF_4321_DCBA;
    core_data[10] = 64'hA5A5_5A5A_C3C3_3C3C;
    bus.core_dout_req[7] = 1'b1;
    wait_grants(1, 10, "t3_first");
    t = 0;
    while (bus.empty && t < 40) begin
      @(negedge CLK);
      t++;
    end
    step(1);
    bus.core_dout_req[9] = 1'b1;
    wait_grants(2, 10, "t3_second");
    bus.core_dout_req[10] = 1'b1;
    base_ready = n_ready;
    step(40);
    check("t3_no_new_grant", 68'(grant_log.size()), 68'd2);
    check("t3_no_pulse", 68'(n_ready - base_ready), 68'd0);
    check("t3_not_idle", 68'(bus.idle), 68'd0);
    check("t3_held_dout", 68'(bus.dout), 68'h7777_0000_1234_ABCD);
    check("t3_held_core", 68'(bus.core_num), 68'd7);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    @(negedge CLK);
    check("t3_still_full", 68'(bus.empty), 68'd0);
    check("t3_replaced", 68'(bus.dout), 68'h9999_FFFF_4321_DCBA);
    check("t3_replaced_core", 68'(bus.core_num), 68'd9);
    step(1);
    bus.rd_en = 1'b1;
    wait_pops(base_pop + 3, 100, "t3_records");
    check("t3_third_core", 68'(grant_log.size() > 2 ? grant_log[2] : -1), 68'd10);

    // 4: core 1 masked
    step(2);
    clear_logs();
    base_pop   = n_pop;
    base_ready = n_ready;
    bus.DUMMY_CORES = 16'h0002;
    core_data[2] = 64'h2222_1111_ABAB_CDCD;
    bus.core_dout_req[1] = 1'b1;
    bus.core_dout_req[2] = 1'b1;
    wait_pops(base_pop + 1, 60, "t4_record");
    step(30);
    check("t4_n_grants", 68'(grant_log.size()), 68'd1);
    check("t4_grant_core", 68'(grant_log.size() > 0 ? grant_log[0] : -1), 68'd2);
    check("t4_pulses", 68'(n_ready - base_ready), 68'd1);
    check("t4_idle", 68'(bus.idle), 68'd1);
    bus.core_dout_req = '0;
    bus.DUMMY_CORES   = '0;

    // 5: reset during nibble 7 of core 4's stream
    step(2);
    clear_logs();
    base_pop = n_pop;
    core_data[4] = 64'h4444_3333_2222_1111;
    core_data[0] = 64'h0F1E_2D3C_4B5A_6978;
    bus.core_dout_req[4] = 1'b1;
    wait_grants(1, 10, "t5_grant");
    t = 0;
    while (grant_cyc.size() > 0 && cyc < grant_cyc[0] + 9 && t < 20) begin
      step(1);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("t5_ready", 68'(bus.core_dout_ready), 68'd0);
    check("t5_empty", 68'(bus.empty), 68'd1);
    check("t5_dout", 68'(bus.dout), 68'd0);
    bus.core_dout_req[0] = 1'b1;
    bus.core_dout_req[4] = 1'b1;
    step(2);
    rst_n = 1'b1;
    wait_pops(base_pop + 2, 80, "t5_records");
    check("t5_n_grants", 68'(grant_log.size()), 68'd3);
    check("t5_first_after", 68'(grant_log.size() > 1 ? grant_log[1] : -1), 68'd0);
    check("t5_second_after", 68'(grant_log.size() > 2 ? grant_log[2] : -1), 68'd4);
    step(3);
    check("t5_sb_drained", 68'(sb_q.size()), 68'd0);
    check("t5_idle", 68'(bus.idle), 68'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
